// File: rtl/edl_pwm_multi_if.sv
// Avalon-MM register bus for the multi-channel PWM block.
// Zero wait states: readdata is combinational on address.
interface edl_pwm_multi_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/edl_pwm_multi.sv
// Multi-channel PWM generator with shadowed period/prescale/duty registers.
// Software writes the shadow copies; the active copies reload at the period
// boundary, or continuously while the block is disabled.
// Channel enables (CHEN) are not shadowed and act immediately.
module edl_pwm_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PRE_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  edl_pwm_multi_if.slave    bus,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [3:0] AddrCtrl     = 4'd0;
  localparam logic [3:0] AddrPeriod   = 4'd1;
  localparam logic [3:0] AddrPrescale = 4'd2;
  localparam logic [3:0] AddrChen     = 4'd3;
  localparam int unsigned DutyBase    = 4;

  // Shadow (software-visible) registers
  logic              en_q, en_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [PRE_W-1:0]  prescale_q, prescale_d;
  logic [NUM_CH-1:0] chen_q, chen_d;
  logic [CNT_W-1:0]  duty_q [NUM_CH];
  logic [CNT_W-1:0]  duty_d [NUM_CH];

  // Active copies used by the counters and comparators
  logic [CNT_W-1:0]  period_act_q;
  logic [PRE_W-1:0]  prescale_act_q;
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];

  // Counters and outputs
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;

  logic              wr_en;
  logic              shadow_wr;
  logic              tick;
  logic              boundary;
  logic              act_load;
  logic [31:0]       rdata;
  logic              unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  assign tick     = en_q && (pre_cnt_q == prescale_act_q);
  assign boundary = tick && (cnt_q == period_act_q);
  // While disabled the active copies follow the shadows every cycle, so an
  // enable starts straight away with the current settings.
  assign act_load = ~en_q | boundary;

  // Decode register writes into next shadow values
  always_comb begin
    en_d       = en_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    chen_d     = chen_q;
    duty_d     = duty_q;
    shadow_wr  = 1'b0;
    if (wr_en) begin
      case (bus.address)
        AddrCtrl: en_d = bus.writedata[0];
        AddrPeriod: begin
          period_d  = bus.writedata[CNT_W-1:0];
          shadow_wr = 1'b1;
        end
        AddrPrescale: begin
          prescale_d = bus.writedata[PRE_W-1:0];
          shadow_wr  = 1'b1;
        end
        AddrChen: chen_d = bus.writedata[NUM_CH-1:0];
        default: begin
          for (int n = 0; n < int'(NUM_CH); n++) begin
            if (bus.address == 4'(DutyBase + n)) begin
              duty_d[n] = bus.writedata[CNT_W-1:0];
              shadow_wr = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Update-pending flag: a same-cycle write beats the boundary clear
  always_comb begin
    pend_d = pend_q;
    if (!en_d) begin
      pend_d = 1'b0;
    end else if (shadow_wr && en_q) begin
      pend_d = 1'b1;
    end else if (boundary) begin
      pend_d = 1'b0;
    end
  end

  // Prescaler and period counter next state
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    if (!en_q) begin
      pre_cnt_d = '0;
      cnt_d     = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
      cnt_d     = boundary ? '0 : cnt_q + CNT_W'(1);
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  // Per-channel compare against the active duty
  always_comb begin
    pwm_d = '0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      pwm_d[n] = en_q & chen_q[n] & (cnt_q < duty_act_q[n]);
    end
  end

  // Shadow register bank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      pend_q     <= 1'b0;
      period_q   <= '0;
      prescale_q <= '0;
      chen_q     <= '0;
      duty_q     <= '{default: '0};
    end else begin
      en_q       <= en_d;
      pend_q     <= pend_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      chen_q     <= chen_d;
      duty_q     <= duty_d;
    end
  end

  // Active copies load from the pre-write shadow values
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_act_q   <= '0;
      prescale_act_q <= '0;
      duty_act_q     <= '{default: '0};
    end else if (act_load) begin
      period_act_q   <= period_q;
      prescale_act_q <= prescale_q;
      duty_act_q     <= duty_q;
    end
  end

  // Counters and registered PWM outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      pwm_q     <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  // Read mux returns the shadow values; unmapped addresses read 0
  always_comb begin
    rdata = '0;
    case (bus.address)
      AddrCtrl:     rdata[1:0]        = {pend_q, en_q};
      AddrPeriod:   rdata[CNT_W-1:0]  = period_q;
      AddrPrescale: rdata[PRE_W-1:0]  = prescale_q;
      AddrChen:     rdata[NUM_CH-1:0] = chen_q;
      default: begin
        for (int n = 0; n < int'(NUM_CH); n++) begin
          if (bus.address == 4'(DutyBase + n)) begin
            rdata[CNT_W-1:0] = duty_q[n];
          end
        end
      end
    endcase
  end

  assign bus.readdata = rdata;
  assign pwm_out      = pwm_q;

endmodule
